// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and show-ahead head word.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: FIFO-fed frame serialiser gated by enb.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enb,
  input  logic                            wr_valid,
  input  logic [DATA_BITS-1:0]            wr_data,
  output logic                            wr_ready,
  output logic                            tx_data,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            clr_ovf
);
  localparam int      CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int      IW       = 4;
  localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

  tx_state_e            state, state_nx;
  logic [CW-1:0]        baud;
  logic [IW-1:0]        idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx, head;
  logic                 par_q, par_nx;
  logic                 pop, new_bit, bit_done, start_ok;
  logic                 tx_nx, busy_nx;
  logic                 full, empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid && wr_ready),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign wr_ready = !full;
  assign bit_done = (baud == '0);
  assign start_ok = enb && !empty;

  // State register, baud counter and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tx_data <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      shreg   <= shreg_nx;
      par_q   <= par_nx;
      tx_data <= tx_nx;
      busy    <= busy_nx;
      if (new_bit)        baud <= CW'(CLKS_PER_BIT - 1);
      else if (!bit_done) baud <= baud - CW'(1);
    end
  end

  // Next-state: a pop loads the shifter and latches the word's parity.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    shreg_nx = shreg;
    par_nx   = par_q;
    pop      = 1'b0;
    new_bit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          pop      = 1'b1;
          shreg_nx = head;
          par_nx   = (^head) ^ (PAR_MODE == PAR_ODD);
          state_nx = ST_START;
          new_bit  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_nx = ST_DATA;
          idx_nx   = '0;
          new_bit  = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          new_bit = 1'b1;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_nx   = '0;
            state_nx = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_nx   = idx + IW'(1);
            shreg_nx = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_nx = ST_STOP;
          idx_nx   = '0;
          new_bit  = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (idx == IW'(STOP_BITS - 1)) begin
            idx_nx = '0;
            if (start_ok) begin
              pop      = 1'b1;
              shreg_nx = head;
              par_nx   = (^head) ^ (PAR_MODE == PAR_ODD);
              state_nx = ST_START;
              new_bit  = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            idx_nx  = idx + IW'(1);
            new_bit = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Line level for the coming cycle, registered above.
  always_comb begin
    tx_nx   = 1'b1;
    busy_nx = (state_nx != ST_IDLE);
    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = shreg_nx[0];
      ST_PARITY: tx_nx = par_nx;
      default:   tx_nx = 1'b1;
    endcase
  end

  // A refused write wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (wr_valid && !wr_ready) overflow <= 1'b1;
    else if (clr_ovf)               overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboarded bench: three transmitter configurations decoded by line monitors.
module tb_uart_tx_stream;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]      enb = '0, wr_valid = '0, clr_ovf = '0, chk_gap = '0;
  logic [2:0][8:0] wr_data = '0;
  logic [2:0]      tx, busy, wr_ready, ovf;
  logic [2:0][4:0] cnt;
  logic [8:0]      q0[$], q1[$], q2[$];
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int i, input logic [8:0] d);
    case (i)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  task automatic pop_exp(input int i, output bit ok, output logic [8:0] d);
    ok = 1'b0;
    d  = '0;
    case (i)
      0: if (q0.size() != 0) begin ok = 1'b1; d = q0.pop_front(); end
      1: if (q1.size() != 0) begin ok = 1'b1; d = q1.pop_front(); end
      default: if (q2.size() != 0) begin ok = 1'b1; d = q2.pop_front(); end
    endcase
  endtask

  // 0: 8N1, 1: 8E1, 2: 7O2
  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int DB = (gi == 2) ? 7 : 8;
    localparam int PAR = gi;
    localparam int SB = (gi == 2) ? 2 : 1;
    localparam int NB = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FL = CPB * NB;

    uart_tx_stream #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(16), .PARITY(PAR), .STOP_BITS(SB)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .enb        (enb[gi]),
      .wr_valid   (wr_valid[gi]),
      .wr_data    (wr_data[gi][DB-1:0]),
      .wr_ready   (wr_ready[gi]),
      .tx_data    (tx[gi]),
      .busy       (busy[gi]),
      .fifo_count (cnt[gi]),
      .overflow   (ovf[gi]),
      .clr_ovf    (clr_ovf[gi])
    );

    int          k = 0, idle = 0;
    bit          in_f = 1'b0, ended = 1'b0, ok;
    logic [15:0] bits = '0, eb, mask;
    logic [8:0]  exp;

    // Mid-bit sampling decoder; compares each completed frame with the scoreboard.
    always @(negedge clk) begin
      if (!chk_gap[gi]) ended = 1'b0;
      if (rst) begin
        in_f = 1'b0;
        k    = 0;
      end else begin
        if (!in_f && tx[gi] == 1'b0) begin
          in_f = 1'b1;
          k    = 0;
          if (chk_gap[gi] && ended) chk($sformatf("gap%0d", gi), idle, 0);
        end else if (!in_f) begin
          idle++;
        end
        if (in_f) begin
          if (k % CPB == CPB / 2) bits[k / CPB] = tx[gi];
          k++;
          if (k == FL) begin
            in_f  = 1'b0;
            idle  = 0;
            ended = 1'b1;
            pop_exp(gi, ok, exp);
            chk($sformatf("have%0d", gi), ok, 1);
            eb    = '1;
            eb[0] = 1'b0;
            for (int b = 0; b < DB; b++) eb[1 + b] = exp[b];
            if (PAR != 0) eb[DB + 1] = (^exp[DB-1:0]) ^ (PAR == 2);
            mask = (16'h1 << NB) - 16'h1;
            chk($sformatf("frame%0d_%0h", gi, exp), bits & mask, eb & mask);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [8:0] d, input bit accepted);
    wr_valid[i] = 1'b1;
    wr_data[i]  = d;
    tick();
    wr_valid[i] = 1'b0;
    if (accepted) push_exp(i, d);
  endtask

  task automatic wait_busy(input int i, input logic lvl, input int max, output int n);
    n = 0;
    while (busy[i] !== lvl && n < max) begin
      tick();
      n++;
    end
    chk($sformatf("reach%0d_%0b", i, lvl), busy[i], lvl);
  endtask

  initial begin
    int n, lo, hi;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_busy", busy[i], 0);
      chk("rst_ready", wr_ready[i], 1);
      chk("rst_cnt", cnt[i], 0);
      chk("rst_ovf", ovf[i], 0);
    end

    // Empty-FIFO latency and 8N1 frame length.
    enb[0] = 1'b1;
    put(0, 9'h0A5, 1);
    chk("lat_cnt", cnt[0], 1);
    chk("lat_tx_n1", tx[0], 1);
    chk("lat_busy_n1", busy[0], 0);
    tick();
    chk("lat_tx_n2", tx[0], 0);
    chk("lat_busy_n2", busy[0], 1);
    chk("lat_cnt_n2", cnt[0], 0);
    n = 0;
    lo = 0;
    while (busy[0] && n < 100) begin
      n++;
      if (tx[0] == 1'b0 && n == lo + 1) lo++;
      tick();
    end
    chk("start_len", lo, 4);
    chk("busy_len", n, 40);
    chk("idle_tx", tx[0], 1);

    // Even parity, 44-cycle frame.
    enb[1] = 1'b1;
    put(1, 9'h0A5, 1);
    wait_busy(1, 1'b1, 10, n);
    wait_busy(1, 1'b0, 100, n);
    chk("par_len", n, 44);

    // 7O2, two queued words back to back.
    enb[2] = 1'b1;
    chk_gap[2] = 1'b1;
    put(2, 9'h025, 1);
    put(2, 9'h05A, 1);
    wait_busy(2, 1'b1, 10, n);
    wait_busy(2, 1'b0, 200, n);
    chk("c_len", n, 88);
    chk_gap[2] = 1'b0;

    // Fill with the link held off, then overflow.
    enb[0] = 1'b0;
    for (int i = 0; i < 16; i++) put(0, 9'(i), 1);
    chk("full_cnt", cnt[0], 16);
    chk("full_ready", wr_ready[0], 0);
    clr_ovf[0] = 1'b1;
    put(0, 9'h077, 0);
    clr_ovf[0] = 1'b0;
    chk("ovf_set", ovf[0], 1);
    chk("ovf_cnt", cnt[0], 16);
    chk_gap[0] = 1'b1;
    enb[0] = 1'b1;
    wait_busy(0, 1'b1, 10, n);
    wait_busy(0, 1'b0, 16 * 40 + 20, n);
    chk("b2b_len", n, 640);
    chk("ovf_hold", ovf[0], 1);
    chk_gap[0] = 1'b0;
    clr_ovf[0] = 1'b1;
    tick();
    clr_ovf[0] = 1'b0;
    chk("ovf_clr", ovf[0], 0);
    chk("q0_drained", q0.size(), 0);

    // Drop enb mid-frame with words still queued.
    enb[0] = 1'b0;
    for (int i = 0; i < 4; i++) put(0, 9'h031 + 9'(i), 1);
    enb[0] = 1'b1;
    wait_busy(0, 1'b1, 10, n);
    repeat (10) tick();
    enb[0] = 1'b0;
    wait_busy(0, 1'b0, 60, n);
    chk("hold_cnt", cnt[0], 3);
    hi = 0;
    repeat (50) begin
      tick();
      if (tx[0]) hi++;
    end
    chk("hold_high", hi, 50);
    chk("hold_busy", busy[0], 0);
    chk("hold_cnt2", cnt[0], 3);

    // Reset during a data bit with five words buffered.
    put(0, 9'h041, 1);
    put(0, 9'h042, 1);
    chk("pre_rst_cnt", cnt[0], 5);
    enb[0] = 1'b1;
    wait_busy(0, 1'b1, 10, n);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    chk("mrst_tx", tx[0], 1);
    chk("mrst_busy", busy[0], 0);
    chk("mrst_cnt", cnt[0], 0);
    repeat (5) tick();
    chk("post_rst_busy", busy[0], 0);
    chk("q_all_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised buffered UART transmitter that carries result bytes from `FPGA_top` out on `tx_data`. It accepts words through a valid/ready write port into an internal FIFO. It serialises each word as an asynchronous frame with configurable bit period, data width, parity mode and stop-bit count. Transmission is gated by `enb`, so upstream logic (e.g. after DDR2 init) can pre-load results before the link starts.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `DATA_BITS`, default 8: payload bits per frame, 5–9.
- `FIFO_DEPTH`, default 16: buffered words; power of two, ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk  in  1`: single clock, all logic on posedge.
- `rst  in  1`: reset; **one clock; reset is synchronous and active-high**.
- `enb  in  1`: 1 allows a new frame to start; a frame in progress always completes.
- `wr_valid  in  1`: write request.
- `wr_data  in  DATA_BITS`: word to send.
- `wr_ready  out  1`: FIFO not full.
- `tx_data  out  1`: serial line, idle high.
- `busy  out  1`: frame in progress.
- `fifo_count  out  $clog2(FIFO_DEPTH+1)`: words stored.
- `overflow  out  1`: sticky; set on `wr_valid && !wr_ready`.
- `clr_ovf  in  1`: clears `overflow`.

## Operation
- Write is accepted in a cycle where `wr_valid && wr_ready`. `wr_ready = (fifo_count != FIFO_DEPTH)`, combinational from registered count.
- When full, a write is refused even if a pop happens in the same cycle. A simultaneous write and pop on a non-full, non-empty FIFO leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `enb && fifo_count != 0`, pop the head word into the shift register and go to START.
  - START: `tx_data = 0` for one bit period.
  - DATA: LSB first, `DATA_BITS` bit periods.
  - PARITY: present only if `PARITY != 0`; even parity = XOR of data bits, odd parity = its inverse.
  - STOP: `tx_data = 1` for `STOP_BITS` bit periods.
- On the last cycle of STOP:
  - if `enb && fifo_count != 0`, pop and go directly to START, so frames are back-to-back with no idle gap;
  - otherwise go to IDLE.
- Deasserting `enb` mid-frame has no effect on the current frame; no further pops occur.
- `overflow`: set takes priority over `clr_ovf` in the same cycle. The refused word is dropped.
- Bit timing: a down-counter loads `CLKS_PER_BIT-1` at every bit start. The bit advances when the counter reaches 0. A bit index counts DATA and STOP bits.

## Timing
- Reset values: `tx_data=1`, `busy=0`, `wr_ready=1`, `fifo_count=0`, `overflow=0`, FSM=IDLE, FIFO empty.
- Reset mid-frame: the line returns high on the next cycle and buffered words are discarded.
- All outputs are registered except `wr_ready`.
- Latency with an empty FIFO:
  - write accepted in cycle N;
  - `fifo_count=1` in N+1, with pop in N+1;
  - `tx_data` falls in N+2; `busy` rises in N+2.
- Frame length = `CLKS_PER_BIT × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)` cycles.
- `busy` falls on the first IDLE cycle.
- `fifo_count` updates one cycle after the accepting or popping edge.

## Structure
- Package `uart_pkg`: enum `parity_e` {PAR_NONE, PAR_EVEN, PAR_ODD}, enum `tx_state_e`, and helper function `frame_bits()`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - registered pointers with an extra wrap bit;
  - show-ahead read data;
  - count output.
- The top level holds the FSM, baud counter, shift register and overflow flag.

## Test plan
- Use `CLKS_PER_BIT=4`, `DATA_BITS=8`, `PARITY=0`, `STOP_BITS=1`, `enb=1`.
  - Write `0xA5`: line low from cycle N+2 for 4 cycles.
  - Data bits then read 1,0,1,0,0,1,0,1 at 4 cycles each, followed by 4 high cycles.
  - `busy` is high for exactly 40 cycles.
- `PARITY=1`, write `0xA5`: parity bit 0, frame 44 cycles. With `PARITY=2`: parity bit 1.
- `enb=0`, write 16 words `0x00..0x0F`:
  - `fifo_count=16`, `wr_ready=0`;
  - a 17th write sets `overflow`;
  - assert `enb`: 16 back-to-back frames with no idle cycle between stop and start; payloads appear in order; `overflow` stays set until `clr_ovf`.
- Deassert `enb` mid-frame with 3 words queued: the current frame completes, `tx_data` stays high, and `fifo_count` holds at 3.
- Assert `rst` for 1 cycle during a DATA bit with 5 words queued: next cycle `tx_data=1`, `busy=0`, `fifo_count=0`.
- `STOP_BITS=2`, `DATA_BITS=7`, two queued words: the stop interval is 8 cycles high, then the next start bit follows immediately.
